// File: rtl/mc_upsampler.sv
// mc_upsampler: multi-channel runtime-configurable integer upsampler.
// Each accepted input vector is emitted once (phase 0), followed by Lcur-1
// fill phases that carry zero or, optionally, the held sample.
// Optional feature macro: MC_UPSAMPLER_HOLD_EN (adds hold_mode port and the
// hold register used for zero-order-hold fill phases).
//
// Handshake: in_ready is a pure function of en and the phase counter and
// never looks at in_valid; a sample is taken on any rising clk edge where
// in_valid & in_ready are both high. in_valid is ignored outside phase 0.
module mc_upsampler #(
    parameter int  L_MAX = 8,
    parameter int  WIDTH = 20,
    parameter int  CH    = 2,
    localparam int LW    = $clog2(L_MAX + 1),
    localparam int PW    = (L_MAX > 1) ? $clog2(L_MAX) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [LW-1:0]         l_factor,
`ifdef MC_UPSAMPLER_HOLD_EN
    input  logic                  hold_mode,
`endif
    input  logic                  clr_underrun,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CH*WIDTH-1:0]   dout,
    output logic                  out_valid,
    output logic [PW-1:0]         phase,
    output logic                  underrun
);

    localparam logic [LW-1:0] ONE_C   = LW'(1);
    localparam logic [LW-1:0] L_MAX_C = LW'(L_MAX);

    logic [LW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       lcur_q, lcur_d;
    logic                running_q, running_d;
    logic [CH*WIDTH-1:0] dout_q, dout_d;
    logic                out_valid_q, out_valid_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic                underrun_q, underrun_d;
    logic                set_underrun;
    logic [LW-1:0]       l_new;
    logic [CH*WIDTH-1:0] fill_val;

`ifdef MC_UPSAMPLER_HOLD_EN
    logic [CH*WIDTH-1:0] hold_q, hold_d;
`endif

    // Clamp the requested factor into 1..L_MAX.
    always_comb begin
        l_new = l_factor;
        if (l_factor == '0) begin
            l_new = ONE_C;
        end else if (l_factor > L_MAX_C) begin
            l_new = L_MAX_C;
        end
    end

    // Value driven during fill phases: zero, or the held sample in hold mode.
    always_comb begin
        fill_val = '0;
`ifdef MC_UPSAMPLER_HOLD_EN
        if (hold_mode) begin
            fill_val = hold_q;
        end
`endif
    end

    assign in_ready = en & (cnt_q == '0);

    // Next-state logic: accept / fill / stall, then the sticky underrun flag.
    always_comb begin
        cnt_d        = cnt_q;
        lcur_d       = lcur_q;
        running_d    = running_q;
        dout_d       = dout_q;
        phase_d      = phase_q;
        out_valid_d  = 1'b0;
        underrun_d   = underrun_q;
        set_underrun = 1'b0;
`ifdef MC_UPSAMPLER_HOLD_EN
        hold_d       = hold_q;
`endif
        if (en) begin
            if (cnt_q == '0) begin
                if (in_valid) begin
                    dout_d      = din;
                    phase_d     = '0;
                    out_valid_d = 1'b1;
                    lcur_d      = l_new;
                    cnt_d       = (l_new == ONE_C) ? '0 : ONE_C;
                    running_d   = 1'b1;
`ifdef MC_UPSAMPLER_HOLD_EN
                    hold_d      = din;
`endif
                end else begin
                    dout_d       = '0;
                    set_underrun = running_q;
                end
            end else begin
                dout_d      = fill_val;
                phase_d     = cnt_q[PW-1:0];
                out_valid_d = 1'b1;
                cnt_d       = (cnt_q == lcur_q - ONE_C) ? '0 : cnt_q + ONE_C;
            end
        end
        // A set in the same cycle as a clear takes precedence.
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end
        if (set_underrun) begin
            underrun_d = 1'b1;
        end
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lcur_q      <= ONE_C;
            running_q   <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            phase_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lcur_q      <= lcur_d;
            running_q   <= running_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            phase_q     <= phase_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef MC_UPSAMPLER_HOLD_EN
    // Hold register capturing the last accepted sample vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign phase     = phase_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_mc_upsampler.sv
// Bench for mc_upsampler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a frame-level model.
module tb_mc_upsampler;

    localparam int L_MAX = 8;
    localparam int WIDTH = 20;
    localparam int CH    = 2;
    localparam int LW    = $clog2(L_MAX + 1);
    localparam int PW    = (L_MAX > 1) ? $clog2(L_MAX) : 1;
    localparam int DW    = CH * WIDTH;
`ifdef MC_UPSAMPLER_HOLD_EN
    localparam bit HAS_HOLD = 1'b1;
`else
    localparam bit HAS_HOLD = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [LW-1:0] l_factor;
    logic          hold_mode;
    logic          clr_underrun;
    logic [DW-1:0] din;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic [PW-1:0] phase;
    logic          underrun;

    always #5 clk = ~clk;

    mc_upsampler #(.L_MAX(L_MAX), .WIDTH(WIDTH), .CH(CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .l_factor     (l_factor),
`ifdef MC_UPSAMPLER_HOLD_EN
        .hold_mode    (hold_mode),
`endif
        .clr_underrun (clr_underrun),
        .din          (din),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dout         (dout),
        .out_valid    (out_valid),
        .phase        (phase),
        .underrun     (underrun)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack2(input int c1, input int c0);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = c1[WIDTH-1:0];
        b = c0[WIDTH-1:0];
        return {a, b};
    endfunction

    function automatic int clampf(input int l);
        if (l == 0) return 1;
        if (l > L_MAX) return L_MAX;
        return l;
    endfunction

    // ---------------- behavioural model ----------------
    // A frame is one emitted sample followed by m_left owed fill outputs.
    int            m_left;
    int            m_len;
    bit            m_running;
    logic [DW-1:0] m_hold;
    logic [DW-1:0] e_dout;
    bit            e_valid;
    int            e_phase;
    bit            e_under;

    always @(posedge clk or negedge rst_n) begin
        bit set_u;
        if (!rst_n) begin
            m_left = 0; m_len = 1; m_running = 0; m_hold = '0;
            e_dout = '0; e_valid = 0; e_phase = 0; e_under = 0;
        end else begin
            set_u = 0;
            if (!en) begin
                e_valid = 0;
            end else if (m_left == 0) begin
                if (in_valid) begin
                    m_len     = clampf(int'(l_factor));
                    m_left    = m_len - 1;
                    e_dout    = din;
                    e_phase   = 0;
                    e_valid   = 1;
                    m_running = 1;
                    m_hold    = din;
                end else begin
                    e_valid = 0;
                    e_dout  = '0;
                    set_u   = m_running;
                end
            end else begin
                e_phase = m_len - m_left;
                e_dout  = (HAS_HOLD && hold_mode) ? m_hold : '0;
                e_valid = 1;
                m_left  = m_left - 1;
            end
            if (clr_underrun) e_under = 0;
            if (set_u) e_under = 1;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready",  64'(in_ready),  64'(en && (m_left == 0)));
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("dout",      64'(dout),      64'(e_dout));
            chk("phase",     64'(phase),     64'(e_phase));
            chk("underrun",  64'(underrun),  64'(e_under));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [DW-1:0] va, vb, vh, vc, fill_exp;
    int            exp_ph[5];

    initial begin
        rst_n = 1'b0; en = 1'b0; l_factor = '0; hold_mode = 1'b0;
        clr_underrun = 1'b0; din = '0; in_valid = 1'b0;
        step(2);
        chk_on = 1'b1;
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_phase", 64'(phase), 64'(0));
        chk("rst_under", 64'(underrun), 64'(0));
        rst_n = 1'b1;
        step(1);
        chk("ready_en_low", 64'(in_ready), 64'(0));
        en = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'(1));

        // Zero-stuff by 4 with two vectors.
        va = pack2(-5, 3);
        vb = pack2(7, -1);
        l_factor = LW'(4); in_valid = 1'b1; din = va;
        step(1);
        chk("t1_a", 64'(dout), 64'(va));
        chk("t1_a_ph", 64'(phase), 64'(0));
        din = vb;
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("t1_fill", 64'(dout), 64'(0));
            chk("t1_fill_ph", 64'(phase), 64'(i));
            chk("t1_fill_v", 64'(out_valid), 64'(1));
        end
        step(1);
        chk("t1_b", 64'(dout), 64'(vb));
        step(3);
        chk("t1_b_ph3", 64'(phase), 64'(3));

        // Underrun: two missing samples at a frame boundary, then clear.
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("t2_valid", 64'(out_valid), 64'(0));
            chk("t2_dout", 64'(dout), 64'(0));
            chk("t2_under", 64'(underrun), 64'(1));
        end
        in_valid = 1'b1; clr_underrun = 1'b1; din = va;
        step(1);
        clr_underrun = 1'b0;
        chk("t2_clr", 64'(underrun), 64'(0));
        chk("t2_accept", 64'(dout), 64'(va));

        // Factor change 4->2 while at phase 1.
        step(1);
        chk("t3_ph1", 64'(phase), 64'(1));
        l_factor = LW'(2);
        exp_ph = '{2, 3, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t3_phase", 64'(phase), 64'(exp_ph[i]));
        end

        // Factor 0 behaves as 1, factor L_MAX+3 as L_MAX.
        l_factor = '0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_ready1", 64'(in_ready), 64'(1));
            step(1);
            chk("t4_ph0", 64'(phase), 64'(0));
        end
        l_factor = LW'(L_MAX + 3);
        step(1);
        for (int i = 1; i < L_MAX; i++) begin
            chk("t4_ready_max", 64'(in_ready), 64'(0));
            step(1);
            chk("t4_phmax", 64'(phase), 64'(i));
        end
        chk("t4_ready_end", 64'(in_ready), 64'(1));

        // Hold mode (zero-stuff when the feature is absent) with en pause.
        vh = pack2(100, 100);
        fill_exp = HAS_HOLD ? vh : '0;
        hold_mode = 1'b1; l_factor = LW'(3); din = vh;
        step(1);
        chk("t5_ph0", 64'(dout), 64'(vh));
        step(1);
        chk("t5_ph1", 64'(dout), 64'(fill_exp));
        en = 1'b0;
        step(1);
        chk("t5_frz_dout", 64'(dout), 64'(fill_exp));
        chk("t5_frz_valid", 64'(out_valid), 64'(0));
        chk("t5_frz_phase", 64'(phase), 64'(1));
        en = 1'b1;
        step(1);
        chk("t5_resume_ph", 64'(phase), 64'(2));
        chk("t5_resume_d", 64'(dout), 64'(fill_exp));
        hold_mode = 1'b0;

        // Reset in the middle of an L=8 frame.
        vc = pack2(-77, 12345);
        l_factor = LW'(8); din = vc;
        step(3);
        chk("t6_ph2", 64'(phase), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", 64'(dout), 64'(0));
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_phase", 64'(phase), 64'(0));
        step(1);
        rst_n = 1'b1;
        #1;
        chk("t6_ready", 64'(in_ready), 64'(1));
        step(1);
        chk("t6_restart_ph", 64'(phase), 64'(0));
        chk("t6_restart_d", 64'(dout), 64'(vc));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en           = ($urandom_range(0, 9) != 0);
            in_valid     = ($urandom_range(0, 9) < 8);
            l_factor     = LW'($urandom_range(0, (1 << LW) - 1));
            hold_mode    = $urandom_range(0, 1) == 1;
            clr_underrun = ($urandom_range(0, 19) == 0);
            din          = DW'({$urandom(), $urandom()});
            rst_n        = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(2);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_upsampler.md
# mc_upsampler

Multi-channel, runtime-configurable integer upsampler for the Tx interpolation chain. Accepts one sample vector per frame through a valid/ready handshake. Emits `L` output cycles per accepted sample, either zero-stuffed or zero-order-held, at the fast clock that feeds the comb/integrator stages. Replaces the fixed-factor, single-channel upsampler and adds flow control, underrun detection and a runtime factor.

## Interface
- `L_MAX`, 8: maximum upsampling factor; ≥1.
- `WIDTH`, 20: signed sample width per channel.
- `CH`, 2: number of channels processed in lock-step.
- `LW`, `$clog2(L_MAX+1)`: width of the `l_factor` port. Derived; not overridden.
- `PW`, `$clog2(L_MAX)` (min 1): width of the `phase` port. Derived.

Ports:
- `clk` in 1: fast clock, L × input sample rate.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: global enable; low freezes the block.
- `l_factor` in LW: requested factor, 1..L_MAX.
- `hold_mode` in 1: 0 = zero-stuff, 1 = zero-order hold. Present only under the macro (see Configuration).
- `clr_underrun` in 1: synchronous clear of the `underrun` flag.
- `din` in CH*WIDTH: packed signed samples; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` in 1: `din` is valid.
- `in_ready` out 1: the block will accept `din` this cycle.
- `dout` out CH*WIDTH: packed signed output, registered.
- `out_valid` out 1: `dout` is a valid fast-rate sample, registered.
- `phase` out PW: phase index of the current `dout`, registered.
- `underrun` out 1: sticky; set when an input sample was missing at frame start.

## Operation
- Internal phase counter `cnt` runs 0..Lcur−1. `Lcur` is the active factor.
- `Lcur` is latched from `l_factor` only on an accept (handshake at `cnt == 0`).
- Clamping rule for `l_factor`: 0 → 1; values > L_MAX → L_MAX.
- `in_ready = en & (cnt == 0)`. The signal is combinational and has no dependence on `in_valid`.
- Accept when `in_valid & in_ready`:
  - `dout ← din`, `phase ← 0`, `out_valid ← 1`.
  - Store `din` in the hold register.
  - `cnt ← (Lnew == 1) ? 0 : 1`.
  - Set `running`.
- Fill phases (`en`, `cnt ≠ 0`):
  - `dout ← 0`, or the hold register if `hold_mode`.
  - `phase ← cnt`, `out_valid ← 1`.
  - `cnt ← (cnt == Lcur−1) ? 0 : cnt+1`.
  - `in_valid` is ignored during fill phases.
- Stall (`en`, `cnt == 0`, `!in_valid`):
  - `out_valid ← 0`, `dout ← 0`, `cnt` stays 0.
  - If `running`, set `underrun`.
- `en` low: `cnt`, `dout`, `phase`, `running` and `underrun` all hold. `out_valid ← 0`. `in_ready` is 0.
- `clr_underrun` clears `underrun` in the cycle it is asserted. If the same cycle also sets `underrun`, the set wins.
- Channels share `cnt` and `Lcur`, so all channels stay phase-aligned.
- Arithmetic: samples pass through unmodified. There is no gain compensation; the downstream CIC owns gain.

## Timing
- Reset values: `dout` = 0, `out_valid` = 0, `phase` = 0, `underrun` = 0. Internally `cnt` = 0, `running` = 0, `Lcur` = 1, hold register = 0.
- After reset, `in_ready` is high as soon as `en` is high.
- Latency: an accepted sample appears on `dout` one cycle after the handshake edge.
- With continuous `in_valid`, the block accepts exactly one sample per Lcur cycles and `out_valid` stays high continuously.
- With `Lcur == 1`, `in_ready` is high every enabled cycle, giving a 1-cycle registered pass-through.
- Changing `l_factor` mid-frame has no effect until the next accept. Frames are never truncated.
- Reset mid-frame aborts the frame. The first post-reset accept starts at phase 0.

## Configuration
- Macro: `MC_UPSAMPLER_HOLD_EN`.
- Defined:
  - `hold_mode` port exists.
  - The hold register is instantiated.
  - Fill phases repeat the last accepted sample when `hold_mode` = 1.
- Undefined:
  - `hold_mode` port is absent.
  - No hold register.
  - Fill phases always output 0 (pure zero-stuff).

## Test plan
- Reset, `en`=1, `l_factor`=4, CH=2, continuous `in_valid`, din = {ch1=−5, ch0=3}, then {7, −1}.
  - Required `dout`: {−5,3},0,0,0,{7,−1},0,0,0.
  - `phase` = 0,1,2,3,0…; `out_valid` constantly 1.
- `l_factor`=4, `in_valid` dropped for 2 cycles at a frame boundary.
  - Required: `out_valid` = 0 and `dout` = 0 for 2 cycles; `underrun` = 1.
  - `clr_underrun` then returns `underrun` to 0.
- `l_factor` changed 4→2 at `phase`=1.
  - Required: current frame completes 4 phases; the next frame has 2 phases (0,1).
- `l_factor`=0 and `l_factor`=L_MAX+3.
  - Required: behaviour identical to factor 1 (`in_ready` every cycle) and to factor L_MAX respectively.
- `MC_UPSAMPLER_HOLD_EN` defined, `hold_mode`=1, `l_factor`=3, din=100.
  - Required `dout`: 100,100,100.
  - `en` deasserted at `phase`=1: `dout` holds 100, `out_valid`=0; resume continues at `phase`=2.
- `rst_n` pulsed low at `phase`=2 of an L=8 frame.
  - Required: all outputs 0 immediately.
  - Next `in_valid` is accepted at once and `phase` restarts at 0.
